io_bus_scheduler: RTL
=====================

Name: io_bus_scheduler

Overview:
- Arbitrates the single byte-serial TinyTapeOut IO port between two 32-bit requesters: the instruction-fetch port (IF) and the load/store port (LS).
- Sequences each granted word transaction as byte beats: 4 address beats, then 4 write-data beats or a turnaround plus 4 read-data beats.
- Sits between the CPU-side fetch/LSU logic and the chip pins; replaces ad-hoc per-path byte counters with one shared beat counter.

Parameters:
- BEATS, 4, byte beats per 32-bit word (address and data phases alike); the beat counter is $clog2(BEATS)+1 bits wide.
- TURN_MARK, 8'hFF, value driven on bus_addr_out during the read turnaround beat.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  IF request; held high until if_ack
- if_addr  in  32  IF word address; stable while if_req is high
- if_ack  out  1  one-cycle pulse: IF read complete
- if_rdata  out  32  IF read word; registered
- ls_req  in  1  LS request; held high until ls_ack
- ls_we  in  1  1 = store, 0 = load; stable while ls_req is high
- ls_addr  in  32  LS word address
- ls_wdata  in  32  LS store data
- ls_ack  out  1  one-cycle pulse: LS transaction complete
- ls_rdata  out  32  LS load word; registered
- bus_addr_out  out  8  external address/marker byte
- bus_data_out  out  8  external write-data byte
- bus_data_in  in  8  external read-data byte
- bus_valid  out  1  high on every ADDR and WDATA beat
- bus_we  out  1  write qualifier for the current transaction

Behaviour:
- Reset (rst=0 at a posedge): state=IDLE, beat=0; all bus outputs 0; acks 0; if_rdata=ls_rdata=0; last_grant=IF.
- Reset mid-transaction: the transaction is abandoned; no ack is issued and no rdata is updated.
- All outputs are registered. Every byte lane is LSB first: lane k = word[8k+7:8k].
- IDLE:
  - No request: outputs hold 0.
  - Any request: latch grant, address, we and wdata into internal registers, then go to ADDR with beat=0.
  - IF requests are always reads (we=0).
- ADDR: drive bus_addr_out = addr lane[beat], bus_valid=1, bus_we=we. After BEATS beats, go to WDATA if we=1, else TURN.
- WDATA: drive bus_data_out = wdata lane[beat], bus_valid=1, bus_we=1; bus_addr_out=0. After BEATS beats, go to DONE.
- TURN: one cycle; bus_addr_out=TURN_MARK, bus_valid=0. Go to RDATA with beat=0.
- RDATA: bus_valid=0; capture bus_data_in into the read-assembly lane[beat] each cycle. After BEATS beats, go to DONE.
- DONE: one cycle.
  - Pulse the granted requester's ack.
  - For a read, copy the assembled word into that requester's rdata in the same cycle; the value holds until that requester's next read completes.
  - Update last_grant, then go to IDLE.
- Latency, measured from the IDLE cycle in which req is sampled to the ack cycle:
  - Store: 1+4+4+1 = 10 cycles.
  - Load/fetch: 1+4+1+4+1 = 11 cycles.
- Back-to-back operation: the requester must drop req in the cycle after ack. If req is still high in the next IDLE cycle, that is a new request.
- Arbitration in IDLE (default, fixed priority): LS wins whenever ls_req=1.
- Request inputs are ignored outside IDLE. A request changing mid-transaction does not affect the bus.
- Both acks are never high in the same cycle.
- Illegal state encodings return to IDLE.

Optional Feature:
- Macro: IO_BUS_SCHED_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the requester that is not last_grant. A single requester is always granted.
- Undefined: fixed LS priority as above; last_grant is still kept but does not influence arbitration.

Decomposition:
- Package io_bus_pkg holds:
  - state_t enum: IDLE, ADDR, WDATA, TURN, RDATA, DONE.
  - grant_t enum: GNT_IF, GNT_LS.
  - Constants BEATS_DEF=4 and TURN_MARK_DEF=8'hFF.
- Sub-module io_beat_counter: one instance; synchronous clear and enable, terminal-count output at BEATS-1. It replaces per-phase counters.

Test Plan:
- LS store alone, ls_addr=32'h00000010, ls_wdata=32'hDEADBEEF -> bus_addr_out 10,00,00,00, then bus_data_out EF,BE,AD,DE with bus_we=1; ls_ack exactly 10 cycles after the request is sampled.
- IF fetch alone, if_addr=32'h00000004, bus_data_in driven 13,00,02,20 during RDATA -> TURN cycle shows FF; if_rdata=32'h20020013 with if_ack 11 cycles after sampling.
- Both requests high continuously, macro undefined -> LS is granted on every transaction and IF is starved; never two acks in one cycle.
- Same stimulus with IO_BUS_SCHED_RR_EN -> grants alternate LS, IF, LS, IF, starting with LS (last_grant=IF after reset).
- rst pulled low during the 2nd RDATA beat -> next cycle IDLE, all outputs 0, no ack; a subsequent fetch completes normally.
- LS load at ls_addr=32'h00000020 with bus_data_in 78,56,34,12 -> ls_rdata=32'h12345678; if_rdata keeps its previous value.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the byte-serial IO bus scheduler.
package io_bus_pkg;

  localparam int unsigned BEATS_DEF     = 4;
  localparam logic [7:0]  TURN_MARK_DEF = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    TURN  = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_t;

  // Byte lanes are LSB first: lane k = word[8k+7:8k].
  function automatic logic [7:0] lane_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/io_beat_counter.sv
// Shared beat counter for all byte phases: synchronous clear and enable,
// terminal count when the count reaches BEATS-1.
module io_beat_counter #(
  parameter int unsigned BEATS = 4,
  parameter int unsigned CW    = $clog2(BEATS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-2:0] beat,
  output logic [CW-2:0] beat_next,
  output logic          tc
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign beat      = count_q[CW-2:0];
  assign beat_next = count_d[CW-2:0];
  assign tc        = (count_q == CW'(BEATS - 1));

endmodule

// File: rtl/io_bus_scheduler.sv
// Arbitrates IF and LS word requests onto the byte-serial IO port.
// Define IO_BUS_SCHED_RR_EN for round-robin arbitration; default is fixed LS priority.
module io_bus_scheduler
  import io_bus_pkg::*;
#(
  parameter int unsigned BEATS     = BEATS_DEF,
  parameter logic [7:0]  TURN_MARK = TURN_MARK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic [7:0]  bus_addr_out,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_valid,
  output logic        bus_we
);

  localparam int unsigned CW = $clog2(BEATS) + 1;

`ifdef IO_BUS_SCHED_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  grant_t        gnt_q, gnt_d, last_gnt_q, last_gnt_d, arb_gnt;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic          we_q, we_d;
  logic          cnt_clear, cnt_en, cnt_tc;
  logic [CW-2:0] beat_q, beat_d;
  logic [7:0]    addr_out_d, data_out_d;
  logic          valid_d, we_out_d;

  io_beat_counter #(
    .BEATS(BEATS),
    .CW   (CW)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .beat     (beat_q),
    .beat_next(beat_d),
    .tc       (cnt_tc)
  );

  // last_gnt_q only steers the choice when both requesters contend in round-robin mode.
  assign arb_gnt = (RR_EN && if_req && ls_req) ?
                   ((last_gnt_q == GNT_IF) ? GNT_LS : GNT_IF) :
                   (ls_req ? GNT_LS : GNT_IF);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    asm_d      = asm_q;
    cnt_clear  = 1'b1;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          state_d = ADDR;
          gnt_d   = arb_gnt;
          if (arb_gnt == GNT_LS) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            we_d    = ls_we;
          end else begin
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end
      end
      ADDR: begin
        if (cnt_tc) begin
          state_d = we_q ? WDATA : TURN;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      WDATA: begin
        if (cnt_tc) begin
          state_d = DONE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      TURN: state_d = RDATA;
      RDATA: begin
        asm_d[{beat_q, 3'b000} +: 8] = bus_data_in;
        if (cnt_tc) begin
          state_d = DONE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        last_gnt_d = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the beat they describe.
  always_comb begin
    addr_out_d = 8'h00;
    data_out_d = 8'h00;
    valid_d    = 1'b0;
    we_out_d   = 1'b0;
    case (state_d)
      ADDR: begin
        addr_out_d = lane_of(addr_d, beat_d);
        valid_d    = 1'b1;
        we_out_d   = we_d;
      end
      WDATA: begin
        data_out_d = lane_of(wdata_d, beat_d);
        valid_d    = 1'b1;
        we_out_d   = 1'b1;
      end
      TURN:    addr_out_d = TURN_MARK;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_IF;
      last_gnt_q   <= GNT_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      asm_q        <= '0;
      bus_addr_out <= '0;
      bus_data_out <= '0;
      bus_valid    <= 1'b0;
      bus_we       <= 1'b0;
      if_ack       <= 1'b0;
      ls_ack       <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      asm_q        <= asm_d;
      bus_addr_out <= addr_out_d;
      bus_data_out <= data_out_d;
      bus_valid    <= valid_d;
      bus_we       <= we_out_d;
      if_ack       <= (state_d == DONE) && (gnt_d == GNT_IF);
      ls_ack       <= (state_d == DONE) && (gnt_d == GNT_LS);
      // asm_d already carries the final byte on the RDATA -> DONE edge.
      if ((state_d == DONE) && !we_q) begin
        if (gnt_q == GNT_LS) begin
          ls_rdata <= asm_d;
        end else begin
          if_rdata <= asm_d;
        end
      end
    end
  end

endmodule
